// File: rtl/scalar_wb_unit.sv
// Writeback sequencer in front of the scalar register file: reservation FIFO, pend_vec, 2-step write.
// Define SCALAR_WB_BYPASS_EN to add the fwd_valid/fwd_addr/fwd_data commit-cycle bypass outputs.
module scalar_wb_unit #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned NUM_ESC_REGS = 32,
    parameter int unsigned AW           = 5,
    parameter int unsigned DEPTH        = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    rsv_valid,
    output logic                    rsv_ready,
    input  logic [AW-1:0]           rsv_addr,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic [DATA_WIDTH-1:0]   res_data,
    input  logic                    flush,
    input  logic                    esc_w_busy,
    output logic                    we,
    output logic [AW-1:0]           esc_addr_w,
    output logic [DATA_WIDTH+1:0]   write_data,
    output logic [NUM_ESC_REGS-1:0] pend_vec,
`ifdef SCALAR_WB_BYPASS_EN
    output logic                    fwd_valid,
    output logic [AW-1:0]           fwd_addr,
    output logic [DATA_WIDTH-1:0]   fwd_data,
`endif
    output logic                    fifo_full,
    output logic                    fifo_empty
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    typedef enum logic [1:0] {StIdle, StWait, StCommit} state_e;

    state_e                  state_q;
    logic [AW-1:0]           addr_mem_q [DEPTH];
    logic [PW-1:0]           wr_ptr_q, rd_ptr_q, count;
    logic [AW-1:0]           head_addr;
    logic [NUM_ESC_REGS-1:0] pend_d, flush_mask;
    logic                    in_progress, commit, start, rsv_accept, res_fire;

    assign count       = wr_ptr_q - rd_ptr_q;
    assign head_addr   = addr_mem_q[rd_ptr_q[IW-1:0]];
    assign fifo_empty  = (wr_ptr_q == rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                         (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
    assign in_progress = (state_q != StIdle);
    assign commit      = (state_q == StCommit);
    // flush wins over a same-cycle reservation, so it also masks the handshake
    assign rsv_ready   = !fifo_full && !pend_vec[rsv_addr] && !flush;
    assign rsv_accept  = rsv_valid && rsv_ready;
    assign res_fire    = res_valid && res_ready;
    assign start       = (state_q == StIdle) && !fifo_empty && !esc_w_busy && !flush;

`ifdef SCALAR_WB_BYPASS_EN
    assign fwd_valid = commit;
    assign fwd_addr  = esc_addr_w;
    assign fwd_data  = write_data[DATA_WIDTH-1:0];
`endif

    // Destinations of queued entries that a flush discards; an in-progress head survives.
    always_comb begin
        flush_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((PW'(i) < count) && !((i == 0) && in_progress)) begin
                flush_mask[addr_mem_q[IW'(rd_ptr_q[IW-1:0] + IW'(i))]] = 1'b1;
            end
        end
    end

    always_comb begin
        pend_d = pend_vec;
        if (commit) pend_d[head_addr] = 1'b0;
        if (flush) pend_d = pend_d & ~flush_mask;
        if (rsv_accept) pend_d[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rsv_accept) addr_mem_q[wr_ptr_q[IW-1:0]] <= rsv_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            pend_vec <= '0;
        end else begin
            pend_vec <= pend_d;
            if (commit) rd_ptr_q <= rd_ptr_q + PW'(1);
            if (flush) begin
                wr_ptr_q <= rd_ptr_q + PW'(in_progress);
            end else if (rsv_accept) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            we         <= 1'b0;
            esc_addr_w <= '0;
            write_data <= '0;
            res_ready  <= 1'b0;
        end else begin
            we <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        we         <= 1'b1;
                        esc_addr_w <= head_addr;
                        write_data <= '0;
                        res_ready  <= 1'b1;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (res_fire) begin
                        write_data <= {2'b11, res_data};
                        res_ready  <= 1'b0;
                        state_q    <= StCommit;
                    end
                end
                StCommit: begin
                    write_data <= '0;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_wb_unit.sv
// Self-checking bench for scalar_wb_unit: directed scenarios plus random traffic vs a queue model.
module tb_scalar_wb_unit;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rsv_valid = 1'b0, rsv_ready;
    logic [4:0]  rsv_addr = '0;
    logic        res_valid = 1'b0, res_ready;
    logic [31:0] res_data = '0;
    logic        flush = 1'b0, esc_w_busy = 1'b0;
    logic        we;
    logic [4:0]  esc_addr_w;
    logic [33:0] write_data;
    logic [31:0] pend_vec;
    logic        fifo_full, fifo_empty;
`ifdef SCALAR_WB_BYPASS_EN
    logic        fwd_valid;
    logic [4:0]  fwd_addr;
    logic [31:0] fwd_data;
`endif

    scalar_wb_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rsv_valid  (rsv_valid),
        .rsv_ready  (rsv_ready),
        .rsv_addr   (rsv_addr),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .flush      (flush),
        .esc_w_busy (esc_w_busy),
        .we         (we),
        .esc_addr_w (esc_addr_w),
        .write_data (write_data),
        .pend_vec   (pend_vec),
`ifdef SCALAR_WB_BYPASS_EN
        .fwd_valid  (fwd_valid),
        .fwd_addr   (fwd_addr),
        .fwd_data   (fwd_data),
`endif
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: queue of reserved destinations, pending set, and write phase
    // (0 idle, 1 waiting for result, 2 data on the bus).
    int          mq[$];
    logic [31:0] mpend;
    int          mphase;
    logic        mwe;
    logic [4:0]  maddr;
    logic [33:0] mwd;
    bit          last_acc, last_fire;
    int          cyc = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        mpend  = '0;
        mphase = 0;
        mwe    = 1'b0;
        maddr  = '0;
        mwd    = '0;
    endtask

    // One clock cycle: drive inputs after the falling edge, compare, then advance the model.
    task automatic cycle(input bit rv, input int ra, input bit sv, input logic [31:0] sd,
                         input bit fl, input bit bz);
        bit exp_rr;
        int ph;
        @(negedge clk);
        cyc++;
        rsv_valid  = rv;
        rsv_addr   = ra[4:0];
        res_valid  = sv;
        res_data   = sd;
        flush      = fl;
        esc_w_busy = bz;
        #1;
        exp_rr = (mq.size() < DEPTH) && !mpend[ra] && !fl;
        check("rsv_ready", rsv_ready, exp_rr);
        check("res_ready", res_ready, mphase == 1);
        check("we", we, mwe);
        check("esc_addr_w", esc_addr_w, maddr);
        check("write_data", write_data, mwd);
        check("pend_vec", pend_vec, mpend);
        check("fifo_full", fifo_full, mq.size() == DEPTH);
        check("fifo_empty", fifo_empty, mq.size() == 0);
`ifdef SCALAR_WB_BYPASS_EN
        check("fwd_valid", fwd_valid, mphase == 2);
        if (mphase == 2) begin
            check("fwd_addr", fwd_addr, maddr);
            check("fwd_data", fwd_data, mwd[31:0]);
        end
`endif
        last_acc  = rv && exp_rr;
        last_fire = sv && (mphase == 1);
        ph = mphase;
        case (ph)
            0: begin
                if (mq.size() != 0 && !bz && !fl) begin
                    mwe = 1'b1; maddr = mq[0][4:0]; mwd = '0; mphase = 1;
                end else begin
                    mwe = 1'b0;
                end
            end
            1: begin
                mwe = 1'b0;
                if (last_fire) begin mwd = {2'b11, sd}; mphase = 2; end
            end
            default: begin mwe = 1'b0; mwd = '0; mphase = 0; end
        endcase
        if (fl) begin
            for (int i = (ph != 0) ? 1 : 0; i < mq.size(); i++) mpend[mq[i]] = 1'b0;
            if (ph != 0) begin
                int h;
                h = mq[0];
                mq.delete();
                mq.push_back(h);
            end else begin
                mq.delete();
            end
        end
        if (ph == 2) begin
            mpend[mq[0]] = 1'b0;
            void'(mq.pop_front());
        end
        if (last_acc) begin
            mq.push_back(ra);
            mpend[ra] = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        rsv_valid = 0; res_valid = 0; flush = 0; esc_w_busy = 0;
        #1;
        check("rst_we", we, 0);
        check("rst_esc_addr_w", esc_addr_w, 0);
        check("rst_write_data", write_data, 0);
        check("rst_pend_vec", pend_vec, 0);
        check("rst_res_ready", res_ready, 0);
        check("rst_fifo_empty", fifo_empty, 1);
        check("rst_fifo_full", fifo_full, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (mq.size() == 0 && mphase == 0) return;
            cycle(0, 0, 1, $urandom, 0, 0);
        end
        check("drain_timeout", 1, 0);
    endtask

    initial begin
        int          addrs [3];
        logic [31:0] vals  [3];
        int          k, j, commit_cyc, acc_cyc;

        model_reset();
        do_reset();

        // Single write to r5
        cycle(1, 5, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("t1_we_early", we, 0);
        cycle(0, 0, 1, 32'h0000_002A, 0, 0);
        check("t1_we", we, 1);
        check("t1_addr", esc_addr_w, 5);
        cycle(0, 0, 0, 0, 0, 0);
        check("t1_wdata", write_data, 34'h3_0000_002A);
        check("t1_pend_hold", pend_vec[5], 1);
        cycle(0, 0, 0, 0, 0, 0);
        check("t1_wdata_clr", write_data, 0);
        check("t1_pend_clr", pend_vec[5], 0);

        // Three in-order commits
        addrs[0] = 3; addrs[1] = 7; addrs[2] = 9;
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
        for (int i = 0; i < 3; i++) cycle(1, addrs[i], 0, 0, 0, 0);
        k = 0; j = 0;
        for (int i = 0; i < 40 && j < 3; i++) begin
            cycle(0, 0, 1, vals[k < 3 ? k : 2], 0, 0);
            if (last_fire) k++;
            if (write_data[33]) begin
                check("t2_order_addr", esc_addr_w, addrs[j]);
                check("t2_order_data", write_data[31:0], vals[j]);
                j++;
            end
        end
        check("t2_commits", j, 3);
        drain();

        // WAW stall on r4
        cycle(1, 4, 0, 0, 0, 0);
        cycle(1, 4, 0, 0, 0, 0);
        check("t3_second_blocked", rsv_ready, 0);
        commit_cyc = -1; acc_cyc = -1;
        for (int i = 0; i < 30 && acc_cyc < 0; i++) begin
            cycle(1, 4, 1, $urandom, 0, 0);
            if (write_data[33]) commit_cyc = cyc;
            if (last_acc) acc_cyc = cyc;
        end
        check("t3_accept_after_commit", acc_cyc, commit_cyc + 1);
        drain();

        // Fill FIFO while the register file is busy, then release
        for (int i = 10; i < 14; i++) cycle(1, i, 0, 0, 0, 1);
        cycle(1, 14, 0, 0, 0, 1);
        check("t4_full", fifo_full, 1);
        check("t4_rsv_blocked", rsv_ready, 0);
        check("t5_busy_no_we", we, 0);
        cycle(0, 0, 0, 0, 0, 0);
        check("t5_release_we_lo", we, 0);
        cycle(0, 0, 1, 32'hABCD, 0, 0);
        check("t5_we_pulse", we, 1);
        check("t5_we_addr", esc_addr_w, 10);
        cycle(0, 0, 0, 0, 0, 0);
        check("t4_full_in_commit", fifo_full, 1);
        cycle(0, 0, 0, 0, 0, 0);
        check("t4_not_full", fifo_full, 0);
        drain();

        // Flush while the head waits for its result
        cycle(1, 1, 0, 0, 0, 0);
        cycle(1, 2, 0, 0, 0, 0);
        cycle(1, 6, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 1, 32'h55, 0, 0);
        check("t6_pend_flushed", pend_vec & 32'h44, 0);
        check("t6_head_pending", pend_vec[1], 1);
        cycle(0, 0, 0, 0, 0, 0);
        check("t6_head_commit", write_data, 34'h3_0000_0055);
        check("t6_head_addr", esc_addr_w, 1);
        cycle(0, 0, 0, 0, 0, 0);
        check("t6_empty", fifo_empty, 1);
        check("t6_pend_zero", pend_vec, 0);

        // Random traffic with a mid-run reset
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle($urandom_range(0, 1), $urandom_range(0, 3) == 0 ? $urandom_range(0, 31)
                                                                  : $urandom_range(0, 7),
                  $urandom_range(0, 1), $urandom, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 3) == 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
